// File: rtl/delay_line_ram_pkg.sv
// Shared widths and FSM encodings for the delay-line RAM and its effect clients.
package delay_line_ram_pkg;

  localparam int unsigned DLR_DATA_WIDTH   = 24;
  localparam int unsigned DLR_ADDR_WIDTH   = 12;
  localparam int unsigned DLR_READ_LATENCY = 2;

  typedef logic [2:0] dlr_state_t;

  localparam dlr_state_t StIdle   = 3'd0;
  localparam dlr_state_t StWrite  = 3'd1;
  localparam dlr_state_t StRdAddr = 3'd2;
  localparam dlr_state_t StRdWait = 3'd3;
  localparam dlr_state_t StFinish = 3'd4;

endpackage

// File: rtl/delay_line_ram_if.sv
// smart_ram request/response bundle between an effect engine (master) and the RAM (slave).
interface delay_line_ram_if
  import delay_line_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DLR_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DLR_ADDR_WIDTH
) ();

  logic                  sram_rd;
  logic [ADDR_WIDTH-1:0] sram_offset;
  logic [DATA_WIDTH-1:0] sram_data_out;
  logic                  sram_read_finish;

  modport master (
    output sram_rd,
    output sram_offset,
    input  sram_data_out,
    input  sram_read_finish
  );

  modport slave (
    input  sram_rd,
    input  sram_offset,
    output sram_data_out,
    output sram_read_finish
  );

endinterface

// File: rtl/delay_ram_sp.sv
// Single-port block RAM, read-first, with LATENCY total read stages (first one inside the RAM).
module delay_ram_sp
  import delay_line_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DLR_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DLR_ADDR_WIDTH,
  parameter int unsigned LATENCY    = DLR_READ_LATENCY
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem    [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] pipe_q [LATENCY];

  // Memory write plus free-running read pipeline; the FSM picks the right cycle to consume it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    pipe_q[0] <= mem[addr];
    for (int i = 1; i < int'(LATENCY); i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rdata = pipe_q[LATENCY-1];

endmodule

// File: rtl/delay_line_ram.sv
// Circular sample history with one-at-a-time offset reads for a single effect client.
module delay_line_ram
  import delay_line_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DLR_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DLR_ADDR_WIDTH,
  parameter int unsigned READ_LATENCY = DLR_READ_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  delay_line_ram_if.slave       sram,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  overrun
);

  localparam int unsigned WaitW    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam int unsigned WaitInit = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
  localparam logic [ADDR_WIDTH:0] FillMax = {1'b1, {ADDR_WIDTH{1'b0}}};

  dlr_state_t            state_q, state_d;
  logic [WaitW-1:0]      wait_q, wait_d;
  logic                  wr_pend_q, rd_pend_q, overrun_q;
  logic [DATA_WIDTH-1:0] wr_hold_q, data_q;
  logic [ADDR_WIDTH-1:0] head_q, rd_offset_q, rd_head_q;
  logic [ADDR_WIDTH:0]   fill_q, rd_fill_q;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata, rd_word;

  // Sequencer: live request pulses are honoured in IDLE so an idle read costs 1+READ_LATENCY.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle: begin
        if (wr_pend_q || sample_valid) begin
          state_d = StWrite;
        end else if (rd_pend_q || sram.sram_rd) begin
          state_d = StRdAddr;
        end
      end
      StWrite: state_d = StIdle;
      StRdAddr: begin
        if (READ_LATENCY == 1) begin
          state_d = StFinish;
        end else begin
          state_d = StRdWait;
          wait_d  = WaitW'(WaitInit);
        end
      end
      StRdWait: begin
        if (wait_q == '0) begin
          state_d = StFinish;
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Capture registers, pointers, status and FSM state; memory contents are left untouched on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      wr_pend_q   <= 1'b0;
      wr_hold_q   <= '0;
      overrun_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_offset_q <= '0;
      rd_head_q   <= '0;
      rd_fill_q   <= '0;
      head_q      <= '1;
      fill_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (sample_valid) begin
        wr_hold_q <= sample_in;
        wr_pend_q <= 1'b1;
        // In WRITE the held sample is consumed this cycle, so replacing it is not a loss.
        if (wr_pend_q && (state_q != StWrite)) begin
          overrun_q <= 1'b1;
        end
      end else if (state_q == StWrite) begin
        wr_pend_q <= 1'b0;
      end
      // Snapshot uses pre-write head/fill so a same-cycle push does not shift the read.
      if (sram.sram_rd && !rd_pend_q) begin
        rd_pend_q   <= 1'b1;
        rd_offset_q <= sram.sram_offset;
        rd_head_q   <= head_q;
        rd_fill_q   <= fill_q;
      end else if (state_q == StFinish) begin
        rd_pend_q <= 1'b0;
      end
      if (state_q == StWrite) begin
        head_q <= head_q + ADDR_WIDTH'(1);
        if (fill_q != FillMax) begin
          fill_q <= fill_q + (ADDR_WIDTH + 1)'(1);
        end
      end
      if (state_q == StFinish) begin
        data_q <= rd_word;
      end
    end
  end

  assign ram_we   = (state_q == StWrite);
  assign ram_addr = ram_we ? head_q + ADDR_WIDTH'(1) : rd_head_q - rd_offset_q;

  delay_ram_sp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wr_hold_q),
    .rdata (ram_rdata)
  );

  // Slots not yet written since reset read back as silence.
  assign rd_word = ({1'b0, rd_offset_q} >= rd_fill_q) ? '0 : ram_rdata;

  assign sram.sram_data_out    = (state_q == StFinish) ? rd_word : data_q;
  assign sram.sram_read_finish = (state_q == StFinish);
  assign fill_count            = fill_q;
  assign overrun               = overrun_q;

endmodule
